// File: rtl/rd_circ_buf_arb_pkg.sv
// Shared types for the read circular-buffer arbiter.
// Build option: RD_CIRC_BUF_ARB_FIXED_PRIO_EN selects fixed priority.
package rd_circ_buf_arb_pkg;

  localparam int RD_REQ_W = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ_OUT   = 2'd1,
    RESP_PASS = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [RD_REQ_W-1:0] payload;
  } rd_buf_req_struct;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rd_circ_buf_arb_sel.sv
// Combinational winner select: round-robin from a pointer, or
// lowest-index-first when RD_CIRC_BUF_ARB_FIXED_PRIO_EN is defined.
import rd_circ_buf_arb_pkg::*;

module rd_circ_buf_arb_sel #(
  parameter int NUM_SRCS = 4,
  parameter int SRC_ID_W = $clog2(NUM_SRCS)
) (
  input  logic [NUM_SRCS-1:0] i_valid,
`ifndef RD_CIRC_BUF_ARB_FIXED_PRIO_EN
  input  logic [SRC_ID_W-1:0] i_rr_ptr,
`endif
  output logic [SRC_ID_W-1:0] o_winner,
  output logic                o_any_valid
);

`ifdef RD_CIRC_BUF_ARB_FIXED_PRIO_EN
  always_comb begin
    o_winner    = '0;
    o_any_valid = 1'b0;
    for (int i = NUM_SRCS - 1; i >= 0; i--) begin
      if (i_valid[i]) begin
        o_winner    = SRC_ID_W'(i);
        o_any_valid = 1'b1;
      end
    end
  end
`else
  logic [SRC_ID_W-1:0] w_idx;

  // Scan from the farthest offset down so the nearest one wins.
  always_comb begin
    o_winner    = '0;
    o_any_valid = 1'b0;
    w_idx       = '0;
    for (int i = NUM_SRCS - 1; i >= 0; i--) begin
      w_idx = SRC_ID_W'((32'(i_rr_ptr) + 32'(i)) % NUM_SRCS);
      if (i_valid[w_idx]) begin
        o_winner    = w_idx;
        o_any_valid = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/rd_circ_buf_arb.sv
// Shares one read circular-buffer engine among NUM_SRCS requesters.
// Build option: RD_CIRC_BUF_ARB_FIXED_PRIO_EN selects fixed priority.
import rd_circ_buf_arb_pkg::*;

module rd_circ_buf_arb #(
  parameter int NUM_SRCS = 4,
  parameter int SRC_ID_W = $clog2(NUM_SRCS),
  parameter int REQ_W    = RD_REQ_W,
  parameter int DATA_W   = 512
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRCS-1:0]       src_arb_req_val,
  input  logic [NUM_SRCS*REQ_W-1:0] src_arb_req_data,
  output logic [NUM_SRCS-1:0]       arb_src_req_rdy,
  output logic                      arb_buf_req_val,
  output logic [REQ_W-1:0]          arb_buf_req_data,
  input  logic                      buf_arb_req_rdy,
  input  logic                      buf_arb_resp_data_val,
  input  logic [DATA_W-1:0]         buf_arb_resp_data,
  input  logic                      buf_arb_resp_data_last,
  output logic                      arb_buf_resp_data_rdy,
  output logic [NUM_SRCS-1:0]       arb_src_resp_data_val,
  output logic [DATA_W-1:0]         arb_src_resp_data,
  output logic                      arb_src_resp_data_last,
  input  logic [NUM_SRCS-1:0]       src_arb_resp_data_rdy,
  output logic                      arb_busy,
  output logic [SRC_ID_W-1:0]       arb_cur_src
);

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  logic [SRC_ID_W-1:0] r_grant;
  logic [REQ_W-1:0]    r_req;
  logic [SRC_ID_W-1:0] w_winner;
  logic                w_any_valid;
  logic                w_accept;
  logic                w_done;
  logic [NUM_SRCS-1:0] w_win_oh;
  logic [NUM_SRCS-1:0] w_grant_oh;
  logic [REQ_W-1:0]    w_req_mux;
`ifndef RD_CIRC_BUF_ARB_FIXED_PRIO_EN
  logic [SRC_ID_W-1:0] r_rr_ptr;
`endif

  rd_circ_buf_arb_sel #(
    .NUM_SRCS (NUM_SRCS),
    .SRC_ID_W (SRC_ID_W)
  ) u_sel (
    .i_valid     (src_arb_req_val),
`ifndef RD_CIRC_BUF_ARB_FIXED_PRIO_EN
    .i_rr_ptr    (r_rr_ptr),
`endif
    .o_winner    (w_winner),
    .o_any_valid (w_any_valid)
  );

  assign w_win_oh   = NUM_SRCS'(1) << w_winner;
  assign w_grant_oh = NUM_SRCS'(1) << r_grant;

  always_comb begin
    w_req_mux = '0;
    for (int i = 0; i < NUM_SRCS; i++) begin
      if (w_winner == SRC_ID_W'(i)) begin
        w_req_mux = src_arb_req_data[i*REQ_W +: REQ_W];
      end
    end
  end

  always_comb begin
    w_state_nxt           = r_state;
    w_accept              = 1'b0;
    w_done                = 1'b0;
    arb_src_req_rdy       = '0;
    arb_buf_req_val       = 1'b0;
    arb_buf_resp_data_rdy = 1'b0;
    arb_src_resp_data_val = '0;
    unique case (r_state)
      IDLE: begin
        // Ready is held off while reset is asserted.
        if (w_any_valid && !rst) begin
          arb_src_req_rdy = w_win_oh;
          w_accept        = 1'b1;
          w_state_nxt     = REQ_OUT;
        end
      end
      REQ_OUT: begin
        arb_buf_req_val = 1'b1;
        if (buf_arb_req_rdy) begin
          w_state_nxt = RESP_PASS;
        end
      end
      RESP_PASS: begin
        if (buf_arb_resp_data_val) begin
          arb_src_resp_data_val = w_grant_oh;
        end
        arb_buf_resp_data_rdy = src_arb_resp_data_rdy[r_grant];
        if (buf_arb_resp_data_val && arb_buf_resp_data_rdy
            && buf_arb_resp_data_last) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_req    <= '0;
`ifndef RD_CIRC_BUF_ARB_FIXED_PRIO_EN
      r_rr_ptr <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_req   <= w_req_mux;
        r_grant <= w_winner;
      end
`ifndef RD_CIRC_BUF_ARB_FIXED_PRIO_EN
      if (w_done) begin
        r_rr_ptr <= SRC_ID_W'(wrap_inc(32'(r_grant), NUM_SRCS));
      end
`endif
    end
  end

  assign arb_buf_req_data       = r_req;
  assign arb_src_resp_data      = buf_arb_resp_data;
  assign arb_src_resp_data_last = buf_arb_resp_data_last;
  assign arb_busy               = (r_state != IDLE);
  assign arb_cur_src            = r_grant;

endmodule

// File: tb/tb_rd_circ_buf_arb.sv
// Directed self-checking bench for rd_circ_buf_arb.
// Honours RD_CIRC_BUF_ARB_FIXED_PRIO_EN for grant-order expectations.
module tb_rd_circ_buf_arb;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int RW = 64;
  localparam int DW = 512;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    src_arb_req_val;
  logic [N*RW-1:0] src_arb_req_data;
  logic [N-1:0]    arb_src_req_rdy;
  logic            arb_buf_req_val;
  logic [RW-1:0]   arb_buf_req_data;
  logic            buf_arb_req_rdy;
  logic            buf_arb_resp_data_val;
  logic [DW-1:0]   buf_arb_resp_data;
  logic            buf_arb_resp_data_last;
  logic            arb_buf_resp_data_rdy;
  logic [N-1:0]    arb_src_resp_data_val;
  logic [DW-1:0]   arb_src_resp_data;
  logic            arb_src_resp_data_last;
  logic [N-1:0]    src_arb_resp_data_rdy;
  logic            arb_busy;
  logic [IW-1:0]   arb_cur_src;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rd_circ_buf_arb #(
    .NUM_SRCS (N),
    .REQ_W    (RW),
    .DATA_W   (DW)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .src_arb_req_val        (src_arb_req_val),
    .src_arb_req_data       (src_arb_req_data),
    .arb_src_req_rdy        (arb_src_req_rdy),
    .arb_buf_req_val        (arb_buf_req_val),
    .arb_buf_req_data       (arb_buf_req_data),
    .buf_arb_req_rdy        (buf_arb_req_rdy),
    .buf_arb_resp_data_val  (buf_arb_resp_data_val),
    .buf_arb_resp_data      (buf_arb_resp_data),
    .buf_arb_resp_data_last (buf_arb_resp_data_last),
    .arb_buf_resp_data_rdy  (arb_buf_resp_data_rdy),
    .arb_src_resp_data_val  (arb_src_resp_data_val),
    .arb_src_resp_data      (arb_src_resp_data),
    .arb_src_resp_data_last (arb_src_resp_data_last),
    .src_arb_resp_data_rdy  (src_arb_resp_data_rdy),
    .arb_busy               (arb_busy),
    .arb_cur_src            (arb_cur_src)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] pay(input int s);
    return 64'hA5A5_0000_0000_1000 | 64'(s * 17 + 1);
  endfunction

  task automatic txn(input string tag, input logic [N-1:0] vals,
                     input int exp_src, input int beats);
    logic [N-1:0] oh;
    oh = 4'b0001 << exp_src;
    src_arb_req_val = vals;
    #1;
    chk({tag, "_rdy"}, 64'(arb_src_req_rdy), 64'(oh));
    chk({tag, "_idle_val"}, 64'(arb_buf_req_val), 64'(0));
    step();
    chk({tag, "_req_val"}, 64'(arb_buf_req_val), 64'(1));
    chk({tag, "_src"}, 64'(arb_cur_src), 64'(exp_src));
    chk({tag, "_pay"}, arb_buf_req_data, pay(exp_src));
    buf_arb_req_rdy = 1'b1;
    step();
    buf_arb_req_rdy = 1'b0;
    src_arb_resp_data_rdy = '1;
    for (int b = 0; b < beats; b++) begin
      buf_arb_resp_data_val  = 1'b1;
      buf_arb_resp_data      = DW'(64'hD000 + 64'(b) + 64'(exp_src * 256));
      buf_arb_resp_data_last = (b == beats - 1);
      #1;
      chk({tag, "_rval"}, 64'(arb_src_resp_data_val), 64'(oh));
      chk({tag, "_rdat"}, arb_src_resp_data[63:0],
          64'hD000 + 64'(b) + 64'(exp_src * 256));
      chk({tag, "_rlast"}, 64'(arb_src_resp_data_last),
          64'(b == beats - 1));
      step();
    end
    buf_arb_resp_data_val  = 1'b0;
    buf_arb_resp_data_last = 1'b0;
    chk({tag, "_done_busy"}, 64'(arb_busy), 64'(0));
  endtask

  initial begin
    logic [63:0] got[$];
    int          k;
    int          exp_src;
    logic        stall;
    logic        hs;

    rst                    = 1'b1;
    src_arb_req_val        = '0;
    buf_arb_req_rdy        = 1'b0;
    buf_arb_resp_data_val  = 1'b0;
    buf_arb_resp_data      = '0;
    buf_arb_resp_data_last = 1'b0;
    src_arb_resp_data_rdy  = '0;
    for (int s = 0; s < N; s++) begin
      src_arb_req_data[s*RW +: RW] = pay(s);
    end
    step();
    step();
    src_arb_req_val = 4'hF;
    #1;
    chk("rst_busy", 64'(arb_busy), 64'(0));
    chk("rst_cur", 64'(arb_cur_src), 64'(0));
    chk("rst_req_val", 64'(arb_buf_req_val), 64'(0));
    chk("rst_req_rdy", 64'(arb_src_req_rdy), 64'(0));
    chk("rst_resp_rdy", 64'(arb_buf_resp_data_rdy), 64'(0));
    chk("rst_resp_val", 64'(arb_src_resp_data_val), 64'(0));
    chk("rst_req_data", arb_buf_req_data, 64'(0));
    src_arb_req_val = '0;
    rst = 1'b0;
    step();

    txn("single", 4'b0100, 2, 3);
    src_arb_req_val = '0;

    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int t = 0; t < 5; t++) begin
`ifdef RD_CIRC_BUF_ARB_FIXED_PRIO_EN
      exp_src = 0;
`else
      exp_src = t % N;
`endif
      txn("rr", 4'hF, exp_src, 2);
    end
    src_arb_req_val = '0;

    src_arb_req_val = 4'b0010;
    #1;
    chk("bp_rdy_req", 64'(arb_src_req_rdy), 64'(4'b0010));
    step();
    src_arb_req_val = '0;
    buf_arb_req_rdy = 1'b1;
    step();
    buf_arb_req_rdy = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
      stall = (cyc >= 1 && cyc < 6);
      src_arb_resp_data_rdy  = stall ? 4'b1101 : 4'hF;
      buf_arb_resp_data_val  = 1'b1;
      buf_arb_resp_data      = DW'(64'hBEEF00 + 64'(k));
      buf_arb_resp_data_last = (k == 3);
      #1;
      if (stall) begin
        chk("bp_stall_rdy", 64'(arb_buf_resp_data_rdy), 64'(0));
      end
      hs = arb_buf_resp_data_rdy && arb_src_resp_data_val[1];
      if (hs) got.push_back(arb_src_resp_data[63:0]);
      step();
      if (hs) k++;
    end
    buf_arb_resp_data_val  = 1'b0;
    buf_arb_resp_data_last = 1'b0;
    src_arb_resp_data_rdy  = '1;
    chk("bp_count", 64'(got.size()), 64'(4));
    for (int i = 0; i < got.size(); i++) begin
      chk("bp_beat", got[i], 64'hBEEF00 + 64'(i));
    end
    chk("bp_idle", 64'(arb_busy), 64'(0));

    src_arb_req_val = 4'b0001;
    #1;
    chk("stall_win", 64'(arb_src_req_rdy), 64'(4'b0001));
    step();
    src_arb_req_val = 4'hF;
    for (int c = 0; c < 10; c++) begin
      chk("stall_val", 64'(arb_buf_req_val), 64'(1));
      chk("stall_pay", arb_buf_req_data, pay(0));
      chk("stall_rdy", 64'(arb_src_req_rdy), 64'(0));
      step();
    end
    src_arb_req_val = '0;
    buf_arb_req_rdy = 1'b1;
    step();
    buf_arb_req_rdy        = 1'b0;
    buf_arb_resp_data_val  = 1'b1;
    buf_arb_resp_data_last = 1'b1;
    #1;
    chk("stall_rval", 64'(arb_src_resp_data_val), 64'(4'b0001));
    step();
    buf_arb_resp_data_val  = 1'b0;
    buf_arb_resp_data_last = 1'b0;
    chk("stall_idle", 64'(arb_busy), 64'(0));

    src_arb_req_val = 4'b1000;
    #1;
    chk("mr_win", 64'(arb_src_req_rdy), 64'(4'b1000));
    step();
    src_arb_req_val = '0;
    buf_arb_req_rdy = 1'b1;
    step();
    buf_arb_req_rdy       = 1'b0;
    buf_arb_resp_data_val = 1'b1;
    buf_arb_resp_data     = DW'(64'hC0);
    #1;
    chk("mr_beat1", 64'(arb_src_resp_data_val), 64'(4'b1000));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mr_busy", 64'(arb_busy), 64'(0));
    chk("mr_cur", 64'(arb_cur_src), 64'(0));
    chk("mr_req_val", 64'(arb_buf_req_val), 64'(0));
    chk("mr_resp_val", 64'(arb_src_resp_data_val), 64'(0));
    chk("mr_resp_rdy", 64'(arb_buf_resp_data_rdy), 64'(0));
    buf_arb_resp_data_val = 1'b0;
    src_arb_req_val = 4'b1001;
    #1;
    chk("mr_post_win", 64'(arb_src_req_rdy), 64'(4'b0001));
    step();
    src_arb_req_val = '0;
    chk("mr_post_src", 64'(arb_cur_src), 64'(0));
    chk("mr_post_pay", arb_buf_req_data, pay(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
